// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM loader: data word geometry and loader FSM states.
package rom_loader_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE
    } load_state_t;

endpackage

// File: rtl/rom_loader.sv
// Streams little-endian program bytes into the instruction ROM write port and
// holds the CPU in reset while a load session is running.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic [ADDR_W:0]     load_words,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    output logic                rom_we,
    output logic [ADDR_W-1:0]   rom_waddr,
    output logic [WORD_W-1:0]   rom_wdata,
    output logic                cpu_rst_n,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_err
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    load_state_t     state;
    load_state_t     state_nx;

    logic [1:0]      byte_idx;
    logic [23:0]     lo_bytes;
    logic [ADDR_W:0] words_total;
    logic [ADDR_W:0] last_idx;
    logic            last_word;
    logic            start_ok;
    logic            start_zero;
    logic            start_bad;
    logic            byte_hs;

    assign start_zero = load_start && (load_words == '0);
    assign start_ok   = load_start && (load_words != '0) && (load_words <= MAX_WORDS);
    assign start_bad  = load_start && (load_words > MAX_WORDS);
    assign byte_hs    = byte_valid && (state == ST_RECV);
    assign last_idx   = words_total - (ADDR_W+1)'(1);
    assign last_word  = ({1'b0, rom_waddr} == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        rom_we     = 1'b0;
        load_done  = 1'b0;
        load_busy  = 1'b1;
        case (state)
            ST_IDLE: begin
                load_busy = 1'b0;
                if (start_ok)        state_nx = ST_RECV;
                else if (start_zero) state_nx = ST_DONE;
            end
            ST_RECV: begin
                byte_ready = 1'b1;
                if (byte_valid && (byte_idx == 2'd3)) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                rom_we   = 1'b1;
                state_nx = last_word ? ST_DONE : ST_RECV;
            end
            ST_DONE: begin
                load_done = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // The 4th byte goes straight into rom_wdata, so the output register only
    // ever changes with a complete word and holds it between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx    <= '0;
            lo_bytes    <= '0;
            words_total <= '0;
            rom_waddr   <= '0;
            rom_wdata   <= '0;
            load_err    <= 1'b0;
            cpu_rst_n   <= ~BOOT_HOLD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok || start_zero) load_err <= 1'b0;
                    else if (start_bad)         load_err <= 1'b1;
                    if (start_ok) begin
                        byte_idx    <= '0;
                        rom_waddr   <= '0;
                        words_total <= load_words;
                        cpu_rst_n   <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (byte_hs) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    lo_bytes[7:0]   <= byte_data;
                            2'd1:    lo_bytes[15:8]  <= byte_data;
                            2'd2:    lo_bytes[23:16] <= byte_data;
                            default: rom_wdata       <= {byte_data, lo_bytes};
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (!last_word) rom_waddr <= rom_waddr + ADDR_W'(1);
                end
                ST_DONE: begin
                    cpu_rst_n <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
